// File: rtl/uart_mux_tx.sv
// uart_mux_tx: round-robin aggregator that drains NUM_CH channel RX FIFOs
// and forwards each byte to the host TX FIFO as a {header, data} frame.
//
// Ports:
//   clk           system clock
//   reset         synchronous active-low reset
//   ch_enable     per-channel arbitration enable mask
//   ch_rx_empty   per-channel RX FIFO empty flags
//   ch_rx_data    per-channel RX FIFO head bytes, channel i at [i*DATA_BITS +: DATA_BITS]
//   ch_read       one-hot pop strobe to the channel RX FIFOs
//   host_tx_full  host TX FIFO full flag
//   host_tx_write host TX FIFO write strobe
//   host_tx_data  byte presented to the host TX FIFO
//   busy          high while a frame is in progress
//   cur_ch        granted channel (last served channel while idle)

module uart_mux_tx #(
    parameter int NUM_CH    = 4,
    parameter int CH_BITS   = 2,
    parameter int DATA_BITS = 8,
    parameter logic [DATA_BITS-CH_BITS-1:0] HEADER_PREFIX = 6'b101100
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_CH-1:0]           ch_enable,
    input  logic [NUM_CH-1:0]           ch_rx_empty,
    input  logic [NUM_CH*DATA_BITS-1:0] ch_rx_data,
    output logic [NUM_CH-1:0]           ch_read,
    input  logic                        host_tx_full,
    output logic                        host_tx_write,
    output logic [DATA_BITS-1:0]        host_tx_data,
    output logic                        busy,
    output logic [CH_BITS-1:0]          cur_ch
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        POP    = 2'd1,
        HEADER = 2'd2,
        DATA   = 2'd3
    } state_t;

    state_t                 r_state;
    logic [CH_BITS-1:0]     r_grant_ch;
    logic [CH_BITS-1:0]     r_last_ch;
    logic [DATA_BITS-1:0]   r_data;

    logic [NUM_CH-1:0]      w_elig;
    logic                   w_hit;
    logic [CH_BITS-1:0]     w_hit_ch;
    logic [DATA_BITS-1:0]   w_head;
    logic [NUM_CH-1:0]      w_onehot;

    assign w_elig   = ch_enable & ~ch_rx_empty;
    assign w_head   = ch_rx_data[int'(r_grant_ch)*DATA_BITS +: DATA_BITS];
    assign w_onehot = NUM_CH'(1) << r_grant_ch;

    // Rotating priority: scan from the channel after the last one served,
    // wrapping modulo NUM_CH, and take the first eligible channel.
    always_comb begin
        int idx;
        idx      = 0;
        w_hit    = 1'b0;
        w_hit_ch = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            idx = (int'(r_last_ch) + k) % NUM_CH;
            if (!w_hit && w_elig[idx]) begin
                w_hit    = 1'b1;
                w_hit_ch = CH_BITS'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_grant_ch <= '0;
            r_last_ch  <= CH_BITS'(NUM_CH - 1);
            r_data     <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_hit) begin
                        r_grant_ch <= w_hit_ch;
                        r_state    <= POP;
                    end
                end
                POP: begin
                    r_data  <= w_head;
                    r_state <= HEADER;
                end
                HEADER: begin
                    if (!host_tx_full) begin
                        r_state <= DATA;
                    end
                end
                DATA: begin
                    if (!host_tx_full) begin
                        r_last_ch <= r_grant_ch;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Outputs decode purely from registered state; the write strobe also
    // follows host_tx_full so a full host FIFO is never written.
    always_comb begin
        ch_read       = '0;
        host_tx_write = 1'b0;
        host_tx_data  = '0;
        unique case (r_state)
            POP: begin
                ch_read = w_onehot;
            end
            HEADER: begin
                host_tx_data  = {HEADER_PREFIX, r_grant_ch};
                host_tx_write = ~host_tx_full;
            end
            DATA: begin
                host_tx_data  = r_data;
                host_tx_write = ~host_tx_full;
            end
            default: begin
                ch_read = '0;
            end
        endcase
    end

    assign busy   = (r_state != IDLE);
    assign cur_ch = (r_state == IDLE) ? r_last_ch : r_grant_ch;

endmodule

// File: tb/tb_uart_mux_tx.sv
// tb_uart_mux_tx: randomized and directed bench for uart_mux_tx with a
// frame-level reference model and per-cycle output comparison.

module tb_uart_mux_tx;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  ch_enable = 4'hF;
    logic [3:0]  ch_rx_empty = 4'hF;
    logic [31:0] ch_rx_data = '0;
    logic [3:0]  ch_read;
    logic        host_tx_full = 1'b0;
    logic        host_tx_write;
    logic [7:0]  host_tx_data;
    logic        busy;
    logic [1:0]  cur_ch;

    uart_mux_tx dut (
        .clk          (clk),
        .reset        (reset),
        .ch_enable    (ch_enable),
        .ch_rx_empty  (ch_rx_empty),
        .ch_rx_data   (ch_rx_data),
        .ch_read      (ch_read),
        .host_tx_full (host_tx_full),
        .host_tx_write(host_tx_write),
        .host_tx_data (host_tx_data),
        .busy         (busy),
        .cur_ch       (cur_ch)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] q[4][$];
    logic [3:0] rd_lat = '0;

    logic [7:0] wr_log[$];
    int         wr_cyc[$];
    int         rd_log[$];
    int         rd_cnt[4];
    logic [7:0] exp_q[$];

    // reference model: pending grant, queue of bytes still owed to host
    bit         m_ok = 0;
    int         m_pend = -1;
    int         m_cur = 0;
    int         m_last = 3;
    logic [7:0] wq[$];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h cyc=%0d",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic chk_seq(string nm);
        chk({nm, " len"}, wr_log.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < wr_log.size())
                chk(nm, wr_log[i], exp_q[i]);
        end
    endtask

    task automatic clr_logs();
        wr_log.delete();
        wr_cyc.delete();
        rd_log.delete();
        for (int i = 0; i < 4; i++) rd_cnt[i] = 0;
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            ch_rx_empty[i] = (q[i].size() == 0);
            ch_rx_data[i*8 +: 8] = (q[i].size() != 0) ? q[i][0] : 8'h00;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (rd_lat[i] && q[i].size() != 0) void'(q[i].pop_front());
        end
        drive();
    endtask

    task automatic steps(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        logic [3:0] er;
        logic       ew;
        logic [7:0] ed;
        logic       eb;
        logic [1:0] ec;
        if (m_ok) begin
            er = (m_pend >= 0) ? 4'(1 << m_pend) : 4'h0;
            ew = (wq.size() != 0) && !host_tx_full;
            ed = (wq.size() != 0) ? wq[0] : 8'h00;
            eb = (m_pend >= 0) || (wq.size() != 0);
            ec = eb ? 2'(m_cur) : 2'(m_last);
            if (m_pend >= 0) ec = 2'(m_pend);
            chk("ch_read", ch_read, er);
            chk("host_tx_write", host_tx_write, ew);
            chk("host_tx_data", host_tx_data, ed);
            chk("busy", busy, eb);
            chk("cur_ch", cur_ch, ec);
        end
        rd_lat = ch_read;
        if (host_tx_write) begin
            wr_log.push_back(host_tx_data);
            wr_cyc.push_back(cyc);
        end
        for (int i = 0; i < 4; i++) begin
            if (ch_read[i]) begin
                rd_cnt[i]++;
                rd_log.push_back(i);
            end
        end
        if (!reset) begin
            m_ok   = 1;
            m_pend = -1;
            m_last = 3;
            wq.delete();
        end else if (m_ok) begin
            if (m_pend >= 0) begin
                wq.push_back(8'hB0 | 8'(m_pend));
                wq.push_back(ch_rx_data[m_pend*8 +: 8]);
                m_cur  = m_pend;
                m_pend = -1;
            end else if (wq.size() != 0) begin
                if (!host_tx_full) begin
                    void'(wq.pop_front());
                    if (wq.size() == 0) m_last = m_cur;
                end
            end else begin
                for (int k = 1; k <= 4; k++) begin
                    int idx;
                    idx = (m_last + k) % 4;
                    if (m_pend < 0 && ch_enable[idx] && !ch_rx_empty[idx])
                        m_pend = idx;
                end
            end
        end
    end

    initial begin
        // reset held with all channels holding data
        for (int i = 0; i < 4; i++) q[i].push_back(8'hA0 + 8'(i));
        drive();
        steps(3);
        chk("rst ch_read", ch_read, 4'h0);
        chk("rst write", host_tx_write, 1'b0);
        chk("rst busy", busy, 1'b0);
        chk("rst reads", rd_log.size(), 0);
        clr_logs();
        reset = 1'b1;
        steps(20);
        chk("first grant", (rd_log.size() != 0) ? rd_log[0] : -1, 0);
        exp_q = '{8'hB0, 8'hA0, 8'hB1, 8'hA1,
                  8'hB2, 8'hA2, 8'hB3, 8'hA3};
        chk_seq("rst seq");

        // round robin, two bytes per channel
        clr_logs();
        for (int i = 0; i < 4; i++) begin
            q[i].push_back(8'h10 + 8'(i));
            q[i].push_back(8'h10 + 8'(i));
        end
        drive();
        steps(80);
        exp_q = '{8'hB0, 8'h10, 8'hB1, 8'h11, 8'hB2, 8'h12, 8'hB3, 8'h13,
                  8'hB0, 8'h10, 8'hB1, 8'h11, 8'hB2, 8'h12, 8'hB3, 8'h13};
        chk_seq("rr seq");

        // single byte on ch2
        clr_logs();
        q[2].push_back(8'h5A);
        drive();
        steps(8);
        exp_q = '{8'hB2, 8'h5A};
        chk_seq("single seq");
        chk("single rd", rd_cnt[2], 1);
        if (wr_cyc.size() == 2) chk("single gap", wr_cyc[1] - wr_cyc[0], 1);
        else chk("single wrs", wr_cyc.size(), 2);

        // backpressure: 5 header stall cycles, 3 data stall cycles
        clr_logs();
        q[0].push_back(8'h77);
        host_tx_full = 1'b1;
        drive();
        steps(7);
        host_tx_full = 1'b0;
        step();
        host_tx_full = 1'b1;
        steps(3);
        host_tx_full = 1'b0;
        steps(6);
        exp_q = '{8'hB0, 8'h77};
        chk_seq("bp seq");
        if (wr_cyc.size() == 2) chk("bp gap", wr_cyc[1] - wr_cyc[0], 4);
        else chk("bp wrs", wr_cyc.size(), 2);

        // masking ch1
        clr_logs();
        ch_enable = 4'b1101;
        q[0].push_back(8'h01);
        q[1].push_back(8'h55);
        q[1].push_back(8'h56);
        q[3].push_back(8'h03);
        drive();
        steps(20);
        exp_q = '{8'hB3, 8'h03, 8'hB0, 8'h01};
        chk_seq("mask seq");
        chk("mask ch1 reads", rd_cnt[1], 0);

        // reset during a header stall
        clr_logs();
        q[2].push_back(8'h99);
        host_tx_full = 1'b1;
        drive();
        steps(4);
        reset = 1'b0;
        step();
        chk("mid rst busy", busy, 1'b0);
        chk("mid rst write", host_tx_write, 1'b0);
        reset = 1'b1;
        host_tx_full = 1'b0;
        steps(12);
        chk("mid rst writes", wr_log.size(), 0);
        chk("mid rst popped", q[2].size(), 0);

        // randomized traffic with backpressure, mask changes, resets
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(3) == 0 && q[i].size() < 6)
                    q[i].push_back(8'($urandom));
            end
            if ($urandom_range(15) == 0) ch_enable = 4'($urandom);
            host_tx_full = ($urandom_range(2) == 0);
            reset = ($urandom_range(399) != 0);
            drive();
            step();
        end

        // drain everything
        reset = 1'b1;
        ch_enable = 4'hF;
        host_tx_full = 1'b0;
        drive();
        steps(200);
        chk("drain q", q[0].size() + q[1].size() + q[2].size() + q[3].size(), 0);
        chk("drain busy", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
